onehot_wen_sb: RTL and testbench
================================

Name: onehot_wen_sb

Overview:
- Parametrised successor to the register-file one-hot address decoder.
- Decodes a writeback address into a registered one-hot write-enable vector for the register array, one cycle after the request.
- Maintains a per-register busy scoreboard: bits are set on issue and cleared on writeback, with a WAW-blocking issue handshake and a combinational busy query port.
- Sits between the issue/writeback control and the register-file storage.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers. Must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- ZERO_REG, 1. When 1, register 0 is hardwired: never write-enabled, never busy, never blocks issue.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wb_vld  in  1  writeback request valid
- wb_addr  in  ADDR_W  writeback target register
- dout  out  NUM_REGS  registered one-hot write enable
- err_out  out  1  registered pulse: previous writeback address was out of range
- iss_vld  in  1  issue request valid; marks target busy
- iss_addr  in  ADDR_W  issue target register
- iss_ok  out  1  combinational; issue accepted this cycle
- q_addr  in  ADDR_W  busy query address
- q_busy  out  1  combinational busy bit for q_addr
- busy  out  NUM_REGS  registered scoreboard vector

Behaviour:
- Reset (rst_n=0 at a clk rising edge): dout=0, err_out=0, busy=0. Synchronous only; rst_n has no effect between edges. Reset mid-operation discards any in-flight writeback, so dout is 0 on the following cycle, and clears all busy bits. While rst_n=0, iss_ok is driven 0.
- Decode path, latency 1:
  - If wb_vld=1 at edge N and wb_addr < NUM_REGS, then during cycle N+1 dout has exactly bit wb_addr set and err_out=0.
  - If wb_vld=0, dout=0 next cycle.
  - dout is never held; each enable is a single-cycle pulse. Back-to-back writebacks give back-to-back one-hot pulses.
- Out-of-range: wb_vld=1 with wb_addr >= NUM_REGS gives dout=0 and err_out=1 for one cycle. Busy is unchanged.
- Zero register: with ZERO_REG=1, wb_addr=0 gives dout=0 and err_out=0. busy[0] is constant 0.
- Scoreboard update at each edge, per bit i:
  - set_i = iss_vld & iss_ok & (iss_addr==i)
  - clr_i = wb_vld & (wb_addr==i)
  - busy_i_next = set_i | (busy_i & ~clr_i). Set wins over a same-cycle clear.
- Clear of a non-busy register is legal: the write is still enabled and busy stays 0.
- Issue handshake:
  - iss_ok = iss_vld & rst_n & (iss_addr < NUM_REGS) & (~busy[iss_addr] | (wb_vld & wb_addr==iss_addr)).
  - A same-cycle writeback to the target unblocks issue (bypass).
  - When iss_ok=0, the request is ignored; the requester must hold it and retry.
  - With ZERO_REG=1 and iss_addr=0: iss_ok=iss_vld and busy is unchanged.
- Query: q_busy = busy[q_addr] from the registered state, with no same-cycle bypass. q_busy=0 for q_addr >= NUM_REGS.
- Invariants:
  - dout is onehot0: at most one bit set.
  - The register bits of dout, busy and err_out are never X after the first reset edge.

Test Plan:
1. Reset then wb_vld=1, wb_addr=5'd7 at edge 1 -> cycle 2: dout=32'h0000_0080, err_out=0. Cycle 3: dout=0.
2. Back-to-back wb_addr=3,4,31 -> dout 32'h8, 32'h10, 32'h8000_0000 on consecutive cycles, no gaps.
3. NUM_REGS=24, wb_addr=5'd30 -> next cycle dout=0 and err_out=1 for exactly one cycle. iss_addr=30 gives iss_ok=0.
4. iss_vld, iss_addr=9 -> busy[9]=1, q_addr=9 gives q_busy=1. Second issue to 9 gives iss_ok=0, busy unchanged. Then wb_addr=9 gives busy[9]=0 and dout bit 9 pulses.
5. Same cycle: busy[12]=1, wb_addr=12 and iss_addr=12 -> iss_ok=1, dout bit 12 pulses, busy[12] stays 1 (set wins).
6. ZERO_REG=1: wb_addr=0 gives dout=0, err_out=0. iss_addr=0 gives iss_ok=1, busy stays 0. Assert rst_n=0 mid-stream with busy=32'hF0 and a pending wb -> next cycle busy=0, dout=0.

Source files
------------

// File: rtl/onehot_wen_sb.sv
// Register-file write-enable decoder with a per-register busy scoreboard.
// Writebacks become one-cycle one-hot enables; issues are WAW-blocked against busy targets.
module onehot_wen_sb #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_vld,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] dout,
  output logic                err_out,
  input  logic                iss_vld,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic                iss_ok,
  input  logic [ADDR_W-1:0]   q_addr,
  output logic                q_busy,
  output logic [NUM_REGS-1:0] busy
);

  // Bits that may ever be write-enabled or marked busy.
  localparam logic [NUM_REGS-1:0] WRITABLE =
    (ZERO_REG != 0) ? ~NUM_REGS'(1) : {NUM_REGS{1'b1}};

  // An all-zero result doubles as the out-of-range indication.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      vec[i] = (addr == ADDR_W'(i));
    end
    return vec;
  endfunction

  logic [NUM_REGS-1:0] wb_dec;
  logic [NUM_REGS-1:0] iss_dec;
  logic [NUM_REGS-1:0] q_dec;
  logic                wb_in_range;
  logic                iss_in_range;
  logic                iss_target_busy;
  logic                wb_bypass;

  logic [NUM_REGS-1:0] dout_q, dout_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  assign wb_dec       = decode(wb_addr);
  assign iss_dec      = decode(iss_addr);
  assign q_dec        = decode(q_addr);
  assign wb_in_range  = |wb_dec;
  assign iss_in_range = |iss_dec;

  assign iss_target_busy = |(busy_q & iss_dec);
  assign wb_bypass       = wb_vld && (wb_addr == iss_addr);

  // A writeback landing on the target this cycle frees it, so the issue may proceed.
  assign iss_ok = iss_vld && rst_n && iss_in_range && (!iss_target_busy || wb_bypass);

  // Query reads registered state only; an in-flight set or clear is not visible yet.
  assign q_busy = |(busy_q & q_dec);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps a combinational block from inferring a latch.
    set_vec = '0;
    clr_vec = '0;
    if (iss_ok) set_vec = iss_dec;
    if (wb_vld) clr_vec = wb_dec;

    dout_d = clr_vec & WRITABLE;
    err_d  = wb_vld && !wb_in_range;
    busy_d = (set_vec | (busy_q & ~clr_vec)) & WRITABLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its inputs, independent of statement order.
    if (!rst_n) begin
      dout_q <= '0;
      err_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      dout_q <= dout_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign dout    = dout_q;
  assign err_out = err_q;
  assign busy    = busy_q;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dout_q));

endmodule

// File: tb/tb_onehot_wen_sb.sv
// Directed scoreboard bench for onehot_wen_sb: a 32-register and a 24-register instance.
// The driver pushes hand-computed expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_onehot_wen_sb;

  typedef struct {
    bit          inst;     // 0: 32-register DUT, 1: 24-register DUT
    bit          rst_n;
    bit          wb_vld;
    logic [4:0]  wb_addr;
    bit          iss_vld;
    logic [4:0]  iss_addr;
    logic [4:0]  q_addr;
    bit          exp_ok;   // combinational, this cycle
    bit          exp_qb;   // combinational, this cycle
    logic [31:0] exp_dout; // registered, next cycle
    bit          exp_err;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    int idx;
    bit inst;
    bit ok;
    bit qb;
  } comb_exp_t;

  typedef struct {
    int          tag;
    int          idx;
    bit          inst;
    logic [31:0] dout;
    bit          err;
    logic [31:0] busy;
  } reg_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_vld0 = 1'b0, iss_vld0 = 1'b0;
  logic [4:0]  wb_addr0 = '0, iss_addr0 = '0, q_addr0 = '0;
  logic [31:0] dout0, busy0;
  logic        err0, ok0, qb0;
  logic        wb_vld1 = 1'b0, iss_vld1 = 1'b0;
  logic [4:0]  wb_addr1 = '0, iss_addr1 = '0, q_addr1 = '0;
  logic [23:0] dout1, busy1;
  logic        err1, ok1, qb1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  vec_t      vecs[$];
  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onehot_wen_sb #(.ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .wb_vld(wb_vld0), .wb_addr(wb_addr0), .dout(dout0), .err_out(err0),
    .iss_vld(iss_vld0), .iss_addr(iss_addr0), .iss_ok(ok0),
    .q_addr(q_addr0), .q_busy(qb0), .busy(busy0)
  );

  onehot_wen_sb #(.ADDR_W(5), .NUM_REGS(24), .ZERO_REG(1)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .wb_vld(wb_vld1), .wb_addr(wb_addr1), .dout(dout1), .err_out(err1),
    .iss_vld(iss_vld1), .iss_addr(iss_addr1), .iss_ok(ok1),
    .q_addr(q_addr1), .q_busy(qb1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit inst, input bit rst, input bit wbv, input int wba,
                              input bit iv, input int ia, input int qa,
                              input bit ok, input bit qb,
                              input logic [31:0] d, input bit e, input logic [31:0] b);
    vec_t v;
    v.inst = inst; v.rst_n = rst; v.wb_vld = wbv; v.wb_addr = 5'(wba);
    v.iss_vld = iv; v.iss_addr = 5'(ia); v.q_addr = 5'(qa);
    v.exp_ok = ok; v.exp_qb = qb; v.exp_dout = d; v.exp_err = e; v.exp_busy = b;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n     = v.rst_n;
    wb_vld0   = (v.inst == 1'b0) ? v.wb_vld  : 1'b0;
    wb_addr0  = v.wb_addr;
    iss_vld0  = (v.inst == 1'b0) ? v.iss_vld : 1'b0;
    iss_addr0 = v.iss_addr;
    q_addr0   = v.q_addr;
    wb_vld1   = (v.inst == 1'b1) ? v.wb_vld  : 1'b0;
    wb_addr1  = v.wb_addr;
    iss_vld1  = (v.inst == 1'b1) ? v.iss_vld : 1'b0;
    iss_addr1 = v.iss_addr;
    q_addr1   = v.q_addr;
  endtask

  // Monitor: combinational outputs of the current vector, registered outputs when due.
  comb_exp_t ce;
  reg_exp_t  re;
  always @(negedge clk) begin
    if (comb_q.size() > 0) begin
      ce = comb_q.pop_front();
      check($sformatf("v%0d iss_ok", ce.idx), 32'(ce.inst ? ok1 : ok0), 32'(ce.ok));
      check($sformatf("v%0d q_busy", ce.idx), 32'(ce.inst ? qb1 : qb0), 32'(ce.qb));
    end
    if (reg_q.size() > 0 && reg_q[0].tag == cyc) begin
      re = reg_q.pop_front();
      check($sformatf("v%0d dout", re.idx), re.inst ? {8'h0, dout1} : dout0, re.dout);
      check($sformatf("v%0d err_out", re.idx), 32'(re.inst ? err1 : err0), 32'(re.err));
      check($sformatf("v%0d busy", re.idx), re.inst ? {8'h0, busy1} : busy0, re.busy);
    end
  end

  initial begin
    // inst rst wbv wba iv ia qa | ok qb | dout err busy (next cycle)
    vecs.push_back(mk(0,0,1, 7,1, 3, 0, 0,0, 32'h0,          0, 32'h0));    // reset discards wb, iss_ok forced 0
    vecs.push_back(mk(0,1,1, 7,0, 0, 0, 0,0, 32'h0000_0080,  0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,0, 0, 0, 0,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0,1,1, 3,0, 0, 0, 0,0, 32'h0000_0008,  0, 32'h0));    // back-to-back
    vecs.push_back(mk(0,1,1, 4,0, 0, 0, 0,0, 32'h0000_0010,  0, 32'h0));
    vecs.push_back(mk(0,1,1,31,0, 0, 0, 0,0, 32'h8000_0000,  0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,1, 9, 9, 1,0, 32'h0,          0, 32'h200));  // issue 9, no query bypass
    vecs.push_back(mk(0,1,0, 0,1, 9, 9, 0,1, 32'h0,          0, 32'h200));  // WAW blocked
    vecs.push_back(mk(0,1,1, 9,0, 0, 9, 0,1, 32'h0000_0200,  0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,0, 0, 9, 0,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,1,12, 0, 1,0, 32'h0,          0, 32'h1000));
    vecs.push_back(mk(0,1,1,12,1,12,12, 1,1, 32'h0000_1000,  0, 32'h1000)); // bypass, set wins
    vecs.push_back(mk(0,1,0, 0,0, 0,12, 0,1, 32'h0,          0, 32'h1000));
    vecs.push_back(mk(0,1,1, 5,0, 0, 0, 0,0, 32'h0000_0020,  0, 32'h1000)); // clear of non-busy
    vecs.push_back(mk(0,1,1,12,0, 0, 0, 0,0, 32'h0000_1000,  0, 32'h0));
    vecs.push_back(mk(0,1,1, 0,0, 0, 0, 0,0, 32'h0,          0, 32'h0));    // zero register
    vecs.push_back(mk(0,1,0, 0,1, 0, 0, 1,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,0, 0, 0, 0,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0,1,0, 0,1, 4, 0, 1,0, 32'h0,          0, 32'h10));
    vecs.push_back(mk(0,1,0, 0,1, 5, 0, 1,0, 32'h0,          0, 32'h30));
    vecs.push_back(mk(0,1,0, 0,1, 6, 0, 1,0, 32'h0,          0, 32'h70));
    vecs.push_back(mk(0,1,0, 0,1, 7, 0, 1,0, 32'h0,          0, 32'hF0));
    vecs.push_back(mk(0,1,1,20,0, 0, 5, 0,1, 32'h0010_0000,  0, 32'hF0));
    vecs.push_back(mk(0,0,1, 7,1, 8, 4, 0,1, 32'h0,          0, 32'h0));    // reset mid-stream
    vecs.push_back(mk(0,1,0, 0,0, 0, 4, 0,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(1,1,1,30,1,30,30, 0,0, 32'h0,          1, 32'h0));    // 24 regs: out of range
    vecs.push_back(mk(1,1,0, 0,0, 0, 0, 0,0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(1,1,1,23,1,23,23, 1,0, 32'h0080_0000,  0, 32'h80_0000));
    vecs.push_back(mk(1,1,0, 0,1,24,23, 0,1, 32'h0,          0, 32'h80_0000));
    vecs.push_back(mk(1,1,1,24,0, 0, 0, 0,0, 32'h0,          1, 32'h80_0000));
    vecs.push_back(mk(1,1,1,23,0, 0,23, 0,1, 32'h0080_0000,  0, 32'h0));

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      comb_q.push_back('{idx: i, inst: vecs[i].inst, ok: vecs[i].exp_ok, qb: vecs[i].exp_qb});
      reg_q.push_back('{tag: cyc + 1, idx: i, inst: vecs[i].inst, dout: vecs[i].exp_dout,
                        err: vecs[i].exp_err, busy: vecs[i].exp_busy});
    end
    @(posedge clk);
    #1;
    apply(mk(0,1,0,0,0,0,0,0,0,32'h0,0,32'h0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(comb_q.size() + reg_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
